param_regfile: RTL and testbench



---
 rtl/param_regfile.sv | 192 +++++++++++++++++++
 tb/tb_param_regfile.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_regfile.sv
// -----------------------------------------------------------------------------
// param_regfile
//   Parametrised control/status register file. One byte-enabled write port,
//   NUM_RD_PORTS registered read ports, and a per-register access type chosen
//   by REG_TYPE (0=RW, 1=RO, 2=RC read-to-clear, 3=W1C write-1-to-clear).
//   Register i decodes at word address i.
//
//   Optional feature macro: PARAM_REGFILE_IRQ_EN
//     When defined, an irq output is added:
//       irq = registered |(reg[IRQ_FLAG_IDX] & reg[IRQ_EN_IDX]).
//     When undefined, the port and its logic are absent.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   wr_en        in   write strobe
//   wr_addr      in   write word address
//   wr_data      in   write data
//   wr_be        in   byte enables, bit k covers wr_data[8k+7:8k]
//   rd_en        in   per-port read strobe
//   rd_addr      in   per-port read address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data      out  per-port registered read data (holds when rd_en=0)
//   rd_valid     out  per-port one-cycle pulse, rd_data valid
//   rd_err       out  per-port, qualifies rd_valid: address out of range
//   hw_set_en    in   per-register hardware update strobe
//   hw_set_data  in   per-register hardware update value
//   irq          out  interrupt (PARAM_REGFILE_IRQ_EN only)
//
// Read handshake: a read issued with rd_en[p]=1 at edge N is answered at
// edge N+1 with rd_valid[p]=1 (and rd_err[p] for an out-of-range address);
// there is no backpressure, every port may read every cycle.
// -----------------------------------------------------------------------------
module param_regfile #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_REGS     = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter logic [2*NUM_REGS-1:0]          REG_TYPE  = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter int IRQ_FLAG_IDX = 2,
  parameter int IRQ_EN_IDX   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [DATA_WIDTH/8-1:0]            wr_be,
  input  logic [NUM_RD_PORTS-1:0]            rd_en,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]            rd_valid,
  output logic [NUM_RD_PORTS-1:0]            rd_err,
  input  logic [NUM_REGS-1:0]                hw_set_en,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]     hw_set_data
`ifdef PARAM_REGFILE_IRQ_EN
  ,
  output logic                               irq
`endif
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] TYPE_RW  = 2'd0;
  localparam logic [1:0] TYPE_RO  = 2'd1;
  localparam logic [1:0] TYPE_RC  = 2'd2;
  localparam logic [1:0] TYPE_W1C = 2'd3;

  // Register count widened by one bit so the range check also works when
  // NUM_REGS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] NREGS = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];

  logic [DATA_WIDTH-1:0] be_mask;
  logic                  wr_hit;
  logic [NUM_REGS-1:0]   wr_sel;

  logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rd_hit;
  logic [DATA_WIDTH-1:0] rd_word  [NUM_RD_PORTS];
  logic [NUM_REGS-1:0]   rc_clear;

  // Keeps inputs that a given REG_TYPE mix may leave untouched visibly sunk.
  logic unused_inputs;
  assign unused_inputs = ^{hw_set_en, hw_set_data, wr_data, wr_be};

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    be_mask = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      be_mask[8*k +: 8] = {8{wr_be[k]}};
    end
  end

  assign wr_hit = wr_en && ({1'b0, wr_addr} < NREGS);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_hit && (wr_addr == ADDR_WIDTH'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Read decode. Read data always comes from the current (pre-update)
  // register value, so a same-cycle write or clear is not observed.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_addr
    assign rd_addr_a[p] = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    rc_clear = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_hit[p]  = rd_en[p] && ({1'b0, rd_addr_a[p]} < NREGS);
      rd_word[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr_a[p] == ADDR_WIDTH'(i)) begin
          rd_word[p] = regs[i];
        end
        // Several ports hitting the same RC register OR into one clear.
        if (rd_hit[p] && (rd_addr_a[p] == ADDR_WIDTH'(i))) begin
          rc_clear[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state per register. Hardware set is applied last so that an event
  // bit arriving in the clear cycle survives.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_nxt[i] = regs[i];
      case (REG_TYPE[2*i +: 2])
        TYPE_RW: begin
          if (wr_sel[i]) regs_nxt[i] = (regs[i] & ~be_mask) | (wr_data & be_mask);
        end
        TYPE_RO: begin
          if (hw_set_en[i]) regs_nxt[i] = hw_set_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        TYPE_RC: begin
          if (rc_clear[i]) regs_nxt[i] = '0;
          if (hw_set_en[i]) regs_nxt[i] = regs_nxt[i] | hw_set_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        default: begin // TYPE_W1C
          if (wr_sel[i]) regs_nxt[i] = regs[i] & ~(wr_data & be_mask);
          if (hw_set_en[i]) regs_nxt[i] = regs_nxt[i] | hw_set_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      else     regs[i] <= regs_nxt[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read ports
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
      rd_err   <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        rd_valid[p] <= rd_en[p];
        rd_err[p]   <= rd_en[p] & ~rd_hit[p];
        if (rd_en[p]) rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
      end
    end
  end

`ifdef PARAM_REGFILE_IRQ_EN
  // Registered from the current register contents: irq follows a flag or
  // enable change one cycle later.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(regs[IRQ_FLAG_IDX] & regs[IRQ_EN_IDX]);
  end
`endif

endmodule

// File: tb/tb_param_regfile.sv
// -----------------------------------------------------------------------------
// tb_param_regfile
//   Directed bench for param_regfile configured as
//   reg0=RW (reset A5A5_0000), reg1=RO, reg2=RC, reg3=W1C.
// -----------------------------------------------------------------------------
module tb_param_regfile;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 4;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_be;
  logic [NP-1:0]   rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]   rd_valid;
  logic [NP-1:0]   rd_err;
  logic [NR-1:0]   hw_set_en;
  logic [NR*DW-1:0] hw_set_data;
`ifdef PARAM_REGFILE_IRQ_EN
  logic            irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  param_regfile #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_REGS    (NR),
    .NUM_RD_PORTS(NP),
    .REG_TYPE    (8'b11_10_01_00),
    .RESET_VAL   ({32'h0, 32'h0, 32'h0, 32'hA5A5_0000}),
    .IRQ_FLAG_IDX(2),
    .IRQ_EN_IDX  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .hw_set_en  (hw_set_en),
    .hw_set_data(hw_set_data)
`ifdef PARAM_REGFILE_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    rd_en     = '0;
    hw_set_en = '0;
  endtask

  task automatic drv_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
  endtask

  task automatic drv_read(input int p, input logic [AW-1:0] a);
    rd_en[p]              = 1'b1;
    rd_addr[p*AW +: AW]   = a;
  endtask

  task automatic drv_hw(input int r, input logic [DW-1:0] d);
    hw_set_en[r]            = 1'b1;
    hw_set_data[r*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0; hw_set_data = '0;
    idle();

    // Reset with traffic on every input: reset must override all of it.
    rst = 1'b1;
    drv_write(8'h00, 32'hFFFF_FFFF, 4'hF);
    drv_read(0, 8'h02);
    drv_read(1, 8'h10);
    drv_hw(2, 32'h0000_0080);
    tick();
    tick();
    rst = 1'b0;
    idle();
    check("rst_valid", 32'(rd_valid), 32'h0);
    check("rst_err",   32'(rd_err),   32'h0);
    check("rst_data0", port_data(0),  32'h0);
    check("rst_data1", port_data(1),  32'h0);
`ifdef PARAM_REGFILE_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif

    // Reset value of reg0, one-cycle read latency and valid pulse width.
    drv_read(0, 8'h00);
    tick(); idle();
    check("reset_val_data",  port_data(0),  32'hA5A5_0000);
    check("reset_val_valid", 32'(rd_valid), 32'h1);
    check("reset_val_err",   32'(rd_err),   32'h0);
    tick();
    check("valid_pulse_end", 32'(rd_valid), 32'h0);
    check("rd_data_hold",    port_data(0),  32'hA5A5_0000);

    // reg2 must not have been touched by the hw set issued during reset.
    drv_read(0, 8'h02);
    tick(); idle();
    check("rst_blocks_hw", port_data(0), 32'h0);

    // RW byte enables.
    drv_write(8'h00, 32'h0, 4'hF);
    tick(); idle();
    drv_write(8'h00, 32'h1122_3344, 4'b0101);
    tick(); idle();
    drv_read(1, 8'h00);
    tick(); idle();
    check("rw_be", port_data(1), 32'h0022_0044);

    // RO: software write ignored, hw set loads in full.
    drv_write(8'h01, 32'hFFFF_FFFF, 4'hF);
    tick(); idle();
    drv_read(0, 8'h01);
    tick(); idle();
    check("ro_sw_ignored", port_data(0), 32'h0);
    drv_hw(1, 32'h0000_00C3);
    tick(); idle();
    drv_read(0, 8'h01);
    tick(); idle();
    check("ro_hw_set", port_data(0), 32'h0000_00C3);

    // RC: dual-port read returns the same pre-clear value.
    drv_hw(2, 32'h5);
    tick(); idle();
    drv_read(0, 8'h02);
    drv_read(1, 8'h02);
    tick(); idle();
    check("rc_port0", port_data(0), 32'h5);
    check("rc_port1", port_data(1), 32'h5);
    drv_read(0, 8'h02);
    tick(); idle();
    check("rc_cleared", port_data(0), 32'h0);
    // Event posted in the clear cycle survives the clear.
    drv_hw(2, 32'h5);
    tick(); idle();
    drv_read(1, 8'h02);
    drv_hw(2, 32'h2);
    tick(); idle();
    check("rc_preclear", port_data(1), 32'h5);
    drv_read(1, 8'h02);
    tick(); idle();
    check("rc_set_survives", port_data(1), 32'h2);

    // W1C.
    drv_hw(3, 32'hF);
    tick(); idle();
    drv_write(8'h03, 32'h3, 4'hF);
    tick(); idle();
    drv_read(0, 8'h03);
    tick(); idle();
    check("w1c_clear", port_data(0), 32'hC);
    drv_write(8'h03, 32'h4, 4'hF);
    drv_hw(3, 32'h4);
    tick(); idle();
    drv_read(0, 8'h03);
    tick(); idle();
    check("w1c_hw_wins", port_data(0), 32'hC);
    drv_write(8'h03, 32'hC, 4'b1110);
    tick(); idle();
    drv_read(0, 8'h03);
    tick(); idle();
    check("w1c_be_masked", port_data(0), 32'hC);

    // Same-cycle read and write return the pre-write value.
    drv_write(8'h00, 32'hDEAD_BEEF, 4'hF);
    drv_read(1, 8'h00);
    tick(); idle();
    check("rw_collide_old", port_data(1), 32'h0022_0044);
    drv_read(1, 8'h00);
    tick(); idle();
    check("rw_collide_new", port_data(1), 32'hDEAD_BEEF);

    // Out-of-range read and write.
    drv_read(1, 8'h10);
    tick(); idle();
    check("oor_data",  port_data(1),  32'h0);
    check("oor_valid", 32'(rd_valid), 32'h2);
    check("oor_err",   32'(rd_err),   32'h2);
    drv_write(8'h10, 32'hFFFF_FFFF, 4'hF);
    tick(); idle();
    drv_read(0, 8'h00);
    drv_read(1, 8'h01);
    tick(); idle();
    check("oor_wr_reg0", port_data(0), 32'hDEAD_BEEF);
    check("oor_wr_reg1", port_data(1), 32'h0000_00C3);
    drv_read(0, 8'h03);
    drv_read(1, 8'h02);
    tick(); idle();
    check("oor_wr_reg3", port_data(0), 32'hC);
    check("oor_wr_reg2", port_data(1), 32'h0);

    // No read strobe: data holds, no side effect.
    drv_hw(2, 32'h9);
    tick(); idle();
    tick();
    check("noread_hold", port_data(1), 32'h0);
    drv_read(0, 8'h02);
    tick(); idle();
    check("noread_no_clear", port_data(0), 32'h9);

`ifdef PARAM_REGFILE_IRQ_EN
    // reg3 holds C; clear it so the enable is exactly bit 0.
    drv_write(8'h03, 32'hFFFF_FFFF, 4'hF);
    tick(); idle();
    tick();
    check("irq_idle", 32'(irq), 32'h0);
    drv_hw(2, 32'h1);
    drv_hw(3, 32'h1);
    tick(); idle();
    check("irq_latency", 32'(irq), 32'h0);
    tick();
    check("irq_set", 32'(irq), 32'h1);
    drv_read(0, 8'h02);
    tick(); idle();
    check("irq_clear_cycle", 32'(irq), 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);
`endif

    // Reset overrides a same-cycle write and restores reset values.
    rst = 1'b1;
    drv_write(8'h00, 32'h1234_5678, 4'hF);
    tick();
    rst = 1'b0;
    idle();
    check("rst2_valid", 32'(rd_valid), 32'h0);
    drv_read(0, 8'h00);
    tick(); idle();
    check("rst2_reg0", port_data(0), 32'hA5A5_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
